alu_exec_stage: RTL and testbench



---
 rtl/alu_exec_stage.sv | 120 ++++++++++++
 tb/tb_alu_exec_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Registered execute-stage ALU: decodes ALUFun into arith/logic/shift/compare,
// registers result, flags and destination tag at the EX/MEM boundary.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [RD_W-1:0]  rd_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] Z,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [RD_W-1:0]  rd_out
);

  typedef enum logic [1:0] {
    CLS_ARITH = 2'b00,
    CLS_LOGIC = 2'b01,
    CLS_SHIFT = 2'b10,
    CLS_CMP   = 2'b11
  } alu_class_e;

  alu_class_e       cls;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             res_ill;
  logic             a_neg;
  logic             a_zero;

  assign cls    = alu_class_e'(ALUFun[5:4]);
  assign sum    = ALUFun[0] ? (A - B) : (A + B);
  assign a_neg  = A[WIDTH-1];
  assign a_zero = (A == '0);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    res_ill = 1'b0;
    unique case (cls)
      CLS_ARITH: begin
        res = sum;
        // ADD overflows on like-signed operands, SUB on unlike-signed ones
        res_ovf = Sign && ((A[WIDTH-1] ^ B[WIDTH-1]) == ALUFun[0])
                       && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      CLS_LOGIC: begin
        unique case (ALUFun[3:0])
          4'b1000: res = A & B;
          4'b1110: res = A | B;
          4'b0110: res = A ^ B;
          4'b0001: res = ~(A | B);
          4'b1010: res = A;
          default: res_ill = 1'b1;
        endcase
      end
      CLS_SHIFT: begin
        unique case (ALUFun[1:0])
          2'b00:   res = B << A[4:0];
          2'b01:   res = B >> A[4:0];
          2'b11:   res = WIDTH'($signed(B) >>> A[4:0]);
          default: res_ill = 1'b1;
        endcase
      end
      CLS_CMP: begin
        unique case (ALUFun[3:1])
          3'b001:  res[0] = (A == B);
          3'b000:  res[0] = (A != B);
          3'b010:  res[0] = Sign ? ($signed(A) < $signed(B)) : (A < B);
          3'b110:  res[0] = a_neg || a_zero;
          3'b100:  res[0] = a_neg;
          3'b111:  res[0] = !a_neg && !a_zero;
          default: res_ill = 1'b1;
        endcase
      end
      default: res_ill = 1'b1;
    endcase
    if (res_ill) begin
      res     = '0;
      res_ovf = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      Z         <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      rd_out    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) begin
        Z        <= res;
        zero     <= (res == '0);
        overflow <= res_ovf;
        illegal  <= res_ill;
        rd_out   <= rd_in;
      end else begin
        overflow <= 1'b0;
        illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed corner cases then random
// traffic, checked against an arithmetic reference model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  ALUFun = '0;
  logic        Sign = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  rd_in = '0;
  logic        out_valid;
  logic [31:0] Z;
  logic        zero;
  logic        overflow;
  logic        illegal;
  logic [4:0]  rd_out;

  alu_exec_stage #(.WIDTH(32), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
    .flush(flush), .ALUFun(ALUFun), .Sign(Sign), .A(A), .B(B),
    .rd_in(rd_in), .out_valid(out_valid), .Z(Z), .zero(zero),
    .overflow(overflow), .illegal(illegal), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] z;
    logic        zr;
    logic        ovf;
    logic        ill;
    logic [4:0]  rd;
    logic        known;   // Z/zero/rd_out are unspecified after a flush
  } snap_t;

  snap_t q[$];
  snap_t m;
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [5:0] f, input logic s,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] z, output logic ovf,
                                 output logic ill);
    longint sa, sb, ua, ub, r, p, v;
    int unsigned sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    z = '0; ovf = 1'b0; ill = 1'b0;
    case (f[5:4])
      2'd0: begin
        r = f[0] ? sa - sb : sa + sb;
        z = r[31:0];
        ovf = s && (r > 64'sd2147483647 || r < -64'sd2147483648);
      end
      2'd1: case (f[3:0])
        4'h8: z = a & b;
        4'hE: z = a | b;
        4'h6: z = a ^ b;
        4'h1: z = ~(a | b);
        4'hA: z = a;
        default: ill = 1'b1;
      endcase
      2'd2: begin
        sh = int'(a[4:0]);
        p = longint'(1) << sh;
        case (f[1:0])
          2'd0: begin r = ub * p; z = r[31:0]; end
          2'd1: begin r = ub / p; z = r[31:0]; end
          2'd3: begin
            v = (sb >= 0) ? sb / p : -((-sb + p - 1) / p);
            z = v[31:0];
          end
          default: ill = 1'b1;
        endcase
      end
      default: case (f[3:1])
        3'b001: z = {31'b0, a == b};
        3'b000: z = {31'b0, a != b};
        3'b010: z = {31'b0, s ? (sa < sb) : (ua < ub)};
        3'b110: z = {31'b0, sa <= 0};
        3'b100: z = {31'b0, sa < 0};
        3'b111: z = {31'b0, sa > 0};
        default: ill = 1'b1;
      endcase
    endcase
    if (ill) begin z = '0; ovf = 1'b0; end
  endfunction

  task automatic op(input logic [5:0] f, input logic s, input logic [31:0] a,
                    input logic [31:0] b, input logic [4:0] r, input logic v,
                    input logic st, input logic fl, input logic rs);
    logic [31:0] z;
    logic ovf, ill;
    @(negedge clk);
    ALUFun = f; Sign = s; A = a; B = b; rd_in = r;
    in_valid = v; stall = st; flush = fl; reset = rs;
    @(posedge clk);
    if (!rs) begin
      m = '{v: 1'b0, z: '0, zr: 1'b0, ovf: 1'b0, ill: 1'b0, rd: '0, known: 1'b1};
    end else if (fl) begin
      m.v = 1'b0; m.ovf = 1'b0; m.ill = 1'b0; m.known = 1'b0;
    end else if (!st) begin
      m.v = v;
      if (v) begin
        ref_op(f, s, a, b, z, ovf, ill);
        m.z = z; m.zr = (z == 32'd0); m.ovf = ovf; m.ill = ill; m.rd = r;
        m.known = 1'b1;
      end else begin
        m.ovf = 1'b0; m.ill = 1'b0;
      end
    end
    q.push_back(m);
  endtask

  // Plain single-cycle issue, no pipeline control active
  task automatic go(input logic [5:0] f, input logic s, input logic [31:0] a,
                    input logic [31:0] b, input logic [4:0] r);
    op(f, s, a, b, r, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("out_valid", {31'b0, out_valid}, {31'b0, e.v});
        check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
        check("illegal", {31'b0, illegal}, {31'b0, e.ill});
        if (e.known) begin
          check("Z", Z, e.z);
          check("zero", {31'b0, zero}, {31'b0, e.zr});
          check("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
        end
      end
    end
  end

  logic [5:0]  codes [0:19] = '{6'h00, 6'h01, 6'h18, 6'h1E, 6'h16, 6'h11, 6'h1A,
                                6'h20, 6'h21, 6'h23, 6'h33, 6'h31, 6'h35, 6'h3D,
                                6'h39, 6'h3F, 6'h10, 6'h22, 6'h37, 6'h3B};
  logic [31:0] corners [0:7] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000,
                                 32'hFFFFFFFF, 32'h1F, 32'h5, 32'hFFFFFFFE};

  initial begin : driver
    m = '{v: 1'b0, z: '0, zr: 1'b0, ovf: 1'b0, ill: 1'b0, rd: '0, known: 1'b1};
    // Reset held with in_valid and stall asserted
    op(6'h00, 1, 32'h1, 32'h1, 5'd7, 1, 1, 0, 0);
    op(6'h00, 1, 32'h1, 32'h1, 5'd7, 1, 1, 0, 0);
    go(6'h00, 1, 32'h7FFFFFFF, 32'h1, 5'd3);
    go(6'h00, 0, 32'h7FFFFFFF, 32'h1, 5'd3);
    go(6'h01, 1, 32'h80000000, 32'h1, 5'd4);
    go(6'h23, 0, 32'd31, 32'h80000000, 5'd5);
    go(6'h20, 0, 32'd0, 32'h12345678, 5'd5);
    go(6'h11, 0, 32'h0, 32'h0, 5'd6);
    go(6'h18, 0, 32'hF0F0, 32'hFF00, 5'd7);
    go(6'h35, 1, 32'hFFFFFFFF, 32'h1, 5'd8);
    go(6'h35, 0, 32'hFFFFFFFF, 32'h1, 5'd8);
    go(6'h3D, 0, 32'h0, 32'h0, 5'd9);
    go(6'h3F, 0, 32'h80000000, 32'h0, 5'd10);
    go(6'h33, 0, 32'd5, 32'd5, 5'd11);
    // Stall three cycles with changing operands, then release
    op(6'h00, 0, 32'd1, 32'd2, 5'd12, 1, 1, 0, 1);
    op(6'h18, 0, 32'hFFFF, 32'hF, 5'd13, 1, 1, 0, 1);
    op(6'h01, 1, 32'd9, 32'd3, 5'd14, 1, 1, 0, 1);
    go(6'h1E, 0, 32'hA0, 32'h0B, 5'd15);
    // Flush together with stall, then in_valid=0 holding Z
    op(6'h00, 1, 32'h7FFFFFFF, 32'h1, 5'd16, 1, 1, 1, 1);
    go(6'h16, 0, 32'hFF, 32'h0F, 5'd17);
    op(6'h00, 0, 32'd1, 32'd1, 5'd18, 0, 0, 0, 1);
    // Illegal code then a legal op
    go(6'h10, 0, 32'd3, 32'd4, 5'd19);
    go(6'h1A, 0, 32'hCAFE, 32'd0, 5'd20);
    // Reset asserted during a stall
    op(6'h00, 0, 32'd1, 32'd1, 5'd21, 1, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      logic [5:0]  f;
      int unsigned pick;
      pick = $urandom_range(0, 9);
      f = (pick == 0) ? 6'($urandom) : codes[$urandom_range(0, 19)];
      a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
      op(f, 1'($urandom), a, b, 5'($urandom),
         $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15,
         $urandom_range(0, 99) < 8, $urandom_range(0, 99) >= 2);
    end
    @(negedge clk);
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
